tick_sequencer: RTL and testbench

- Controller for the team's prescaled-tick datapath: a programmable prescaler counter plus the FSM that configures, starts, pauses and stops it.
- Emits one-cycle `tick` pulses every (period+1) `hwclk` cycles.
- Runs either a bounded burst of N ticks or free-runs, and signals completion.
- Sits between the control logic (config/start/stop) and consumers of the slow tick (display refresh, debouncers, game timers).

---
 rtl/tick_sequencer.sv | 135 +++++++++++++
 tb/tb_tick_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sequencer.sv
// Programmable prescaler plus IDLE/RUN/PAUSE controller that emits one-cycle
// ticks every (period+1) clocks. Optional macro: TICK_SEQ_AUTO_RELOAD_EN.
module tick_sequencer #(
  parameter int          CTR_W          = 23,
  parameter int          CNT_W          = 16,
  parameter int unsigned DEFAULT_PERIOD = 5000000
) (
  input  logic             hwclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CTR_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_ticks,
  input  logic             start,
  input  logic             hold,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ticks_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [CTR_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] ticks_q,      ticks_d;
  logic [CTR_W-1:0] ctr_q,        ctr_d;
  logic [CNT_W-1:0] ticks_left_q, ticks_left_d;
  logic             tick_q,       tick_d;
  logic             done_q,       done_d;
  logic             busy_q,       busy_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    period_d     = period_q;
    ticks_d      = ticks_q;
    ctr_d        = ctr_q;
    ticks_left_d = ticks_left_q;
    busy_d       = busy_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          period_d = cfg_period;
          ticks_d  = cfg_ticks;
        end
        // A config accepted on the start edge applies to this run.
        if (start && !stop) begin
          state_d      = S_RUN;
          ctr_d        = '0;
          busy_d       = 1'b1;
          ticks_left_d = cfg_valid ? cfg_ticks : ticks_q;
        end
      end

      S_RUN, S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          ctr_d   = '0;
          busy_d  = 1'b0;
        end else if (hold) begin
          state_d = S_PAUSE;
        end else begin
          // Releasing hold counts on the same edge, so a pause costs exactly
          // the number of cycles hold was sampled high.
          state_d = S_RUN;
          if (ctr_q == period_q) begin
            ctr_d  = '0;
            tick_d = 1'b1;
            if (ticks_q != '0) begin
              ticks_left_d = ticks_left_q - CNT_W'(1);
              if (ticks_left_q == CNT_W'(1)) begin
                done_d = 1'b1;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
                ticks_left_d = ticks_q;
`else
                state_d = S_IDLE;
                busy_d  = 1'b0;
`endif
              end
            end
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hwclk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    if (rst) begin
      state_q      <= S_IDLE;
      period_q     <= CTR_W'(DEFAULT_PERIOD);
      ticks_q      <= '0;
      ctr_q        <= '0;
      ticks_left_q <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      ticks_q      <= ticks_d;
      ctr_q        <= ctr_d;
      ticks_left_q <= ticks_left_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_ready  = (state_q == S_IDLE);
  assign tick       = tick_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign ticks_left = ticks_left_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer: directed scenarios plus random
// traffic, compared each cycle against a countdown-based reference model.
module tb_tick_sequencer;

  localparam int CTR_W = 23;
  localparam int CNT_W = 16;
  localparam int DEF   = 9;

  logic             hwclk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CTR_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_ticks;
  logic             start;
  logic             hold;
  logic             stop;
  logic             tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ticks_left;

  tick_sequencer #(
    .CTR_W         (CTR_W),
    .CNT_W         (CNT_W),
    .DEFAULT_PERIOD(DEF)
  ) dut (
    .hwclk     (hwclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_ticks (cfg_ticks),
    .start     (start),
    .hold      (hold),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .ticks_left(ticks_left)
  );

  always #5 hwclk = ~hwclk;

  // Reference model: a run is "active" and counts down the edges left until
  // the next tick; hold simply skips an edge, stop ends the run.
  bit m_active;
  int m_period, m_ticks, m_left, m_wait;
  bit m_tick, m_done;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_period = DEF;
    m_ticks  = 0;
    m_left   = 0;
    m_wait   = 0;
    m_tick   = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge();
    m_tick = 1'b0;
    m_done = 1'b0;
    if (!m_active) begin
      if (cfg_valid) begin
        m_period = int'(cfg_period);
        m_ticks  = int'(cfg_ticks);
      end
      if (start && !stop) begin
        m_active = 1'b1;
        m_left   = m_ticks;
        m_wait   = m_period + 1;
      end
    end else if (stop) begin
      m_active = 1'b0;
    end else if (!hold) begin
      m_wait--;
      if (m_wait == 0) begin
        m_tick = 1'b1;
        m_wait = m_period + 1;
        if (m_ticks != 0) begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
`ifdef TICK_SEQ_AUTO_RELOAD_EN
            m_left = m_ticks;
`else
            m_active = 1'b0;
`endif
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("tick",       32'(tick),       32'(m_tick));
    check("done",       32'(done),       32'(m_done));
    check("busy",       32'(busy),       32'(m_active));
    check("cfg_ready",  32'(cfg_ready),  32'(!m_active));
    check("ticks_left", 32'(ticks_left), 32'(m_left));
  endtask

  task automatic step();
    @(posedge hwclk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge hwclk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    start     = 1'b0;
    hold      = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic configure(input int period, input int nticks);
    cfg_valid  = 1'b1;
    cfg_period = CTR_W'(period);
    cfg_ticks  = CNT_W'(nticks);
    step();
    cfg_valid  = 1'b0;
  endtask

  // Start a run and report how many edges after the start edge the first
  // tick appears (-1 if none within the budget).
  task automatic start_latency(output int lat);
    lat   = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      step();
      if (tick === 1'b1) lat = i;
    end
  endtask

  int lat, n_ticks, n_dones, first_tick;
  bit found;

  initial begin
    idle_inputs();
    cfg_period = '0;
    cfg_ticks  = '0;
    do_reset();

    // Default period after reset: first tick DEF+1 edges after start.
    start_latency(lat);
    check("reset_default_latency", 32'(lat), 32'(DEF + 1));
    stop = 1'b1; step(); stop = 1'b0;

    // Bounded burst: period 3, 4 ticks.
    configure(3, 4);
    start = 1'b1; step(); start = 1'b0;
    n_ticks = 0; n_dones = 0; first_tick = -1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (tick === 1'b1) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
      if (done === 1'b1) begin
        n_dones++;
        check("done_with_4th_tick", 32'(tick), 32'(1));
        check("done_count_at_done", 32'(n_ticks), 32'(4));
      end
    end
    check("burst_tick_count", 32'(n_ticks), 32'(4));
    check("burst_done_count", 32'(n_dones), 32'(1));
    check("burst_first_tick", 32'(first_tick), 32'(4));

    // Free-run at period 0: tick every cycle, then stop.
    configure(0, 0);
    start = 1'b1; step(); start = 1'b0;
    n_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick === 1'b1) n_ticks++;
    end
    check("freerun_tick_count", 32'(n_ticks), 32'(10));
    stop = 1'b1; step(); stop = 1'b0;
    check("freerun_stop_tick", 32'(tick), 32'(0));
    check("freerun_stop_busy", 32'(busy), 32'(0));

    // Hold for 7 cycles after two counts stretches the first tick by 7.
    configure(5, 3);
    start = 1'b1; step(); start = 1'b0;
    first_tick = -1;
    for (int i = 1; i <= 40; i++) begin
      hold = (i >= 3 && i <= 9);
      step();
      if (tick === 1'b1 && first_tick < 0) first_tick = i;
    end
    hold = 1'b0;
    check("hold_first_tick", 32'(first_tick), 32'(13));
    check("hold_ticks_left", 32'(ticks_left), 32'(0));

    // Stop on the same edge as a terminal count.
    configure(3, 4);
    start = 1'b1; step(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_active && m_left == 3 && m_wait == 1) found = 1'b1;
      else step();
    end
    check("stop_tc_reached", 32'(found), 32'(1));
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_tc_tick", 32'(tick), 32'(0));
    check("stop_tc_done", 32'(done), 32'(0));
    check("stop_tc_busy", 32'(busy), 32'(0));
    check("stop_tc_left", 32'(ticks_left), 32'(3));

    // Config offered while busy is ignored.
    configure(2, 2);
    start = 1'b1; step(); start = 1'b0;
    cfg_valid = 1'b1; cfg_period = CTR_W'(0); cfg_ticks = CNT_W'(7);
    step();
    check("busy_cfg_ready", 32'(cfg_ready), 32'(0));
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    start_latency(lat);
    check("busy_cfg_period_kept", 32'(lat), 32'(3));
    for (int i = 0; i < 6; i++) step();

    // Burst repetition (auto-reload) or single completion.
    configure(1, 2);
    start = 1'b1; step(); start = 1'b0;
    n_dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) n_dones++;
    end
`ifdef TICK_SEQ_AUTO_RELOAD_EN
    check("reload_done_count", 32'(n_dones), 32'(3));
    check("reload_busy", 32'(busy), 32'(1));
`else
    check("single_done_count", 32'(n_dones), 32'(1));
    check("single_busy", 32'(busy), 32'(0));
`endif
    stop = 1'b1; step(); stop = 1'b0;
    check("reload_stop_busy", 32'(busy), 32'(0));

    // Reset mid-run restores the default period.
    configure(2, 0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    start_latency(lat);
    check("midrun_reset_latency", 32'(lat), 32'(DEF + 1));
    stop = 1'b1; step(); stop = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_period = CTR_W'($urandom_range(0, 4));
      cfg_ticks  = CNT_W'($urandom_range(0, 3));
      start      = ($urandom_range(0, 3) == 0);
      hold       = ($urandom_range(0, 4) == 0);
      stop       = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
